maze_pixel_fetch: RTL

Pipelined pixel renderer between the VGA sync generator and the game's dual-port ROMs. For each visible pixel it reads the tile id from the maze map ROM, then reads that tile's texel from the texture ROM, and emits RGB with hsync/vsync delayed to match. It drives one ROM port on each ROM instance; the other ports stay free for game logic such as collision checks.

---
 rtl/maze_pkg.sv | 15 +
 rtl/sync_delay.sv | 37 +++
 rtl/maze_pixel_fetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and constants for the maze pixel renderer
package maze_pkg;

  typedef logic [11:0] color_t;
  typedef logic [3:0]  tile_t;

  localparam int    TILE_PX     = 16;
  localparam int    TILE_BITS   = 4;
  localparam tile_t PLAYER_TILE = 4'hF;

  localparam tile_t FLOOR = 4'd0;
  localparam tile_t WALL  = 4'd1;
  localparam tile_t EXIT  = 4'd2;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - N-stage shift register with asynchronous reset to a parameter value
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/maze_pixel_fetch.sv
// rtl/maze_pixel_fetch.sv - map ROM -> texture ROM -> RGB renderer, 3-clock pipeline
// Optional macro PLAYER_OVERLAY_EN: replaces the tile at the vsync-latched player position.
module maze_pixel_fetch
  import maze_pkg::*;
#(
  parameter int     X_ORIGIN  = 64,
  parameter int     Y_ORIGIN  = 0,
  parameter int     MAP_COLS  = 32,
  parameter int     MAP_ROWS  = 30,
  parameter color_t BG_COLOR  = 12'h000,
  parameter color_t KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_valid,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [4:0]  player_col,
  input  logic [4:0]  player_row,
  output logic        map_en,
  output logic [9:0]  map_addr,
  input  logic [3:0]  map_dout,
  output logic        tex_en,
  output logic [11:0] tex_addr,
  input  logic [11:0] tex_dout,
  output logic [11:0] rgb,
  output logic        rgb_valid,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam logic [9:0] X_SPAN = 10'(TILE_PX * MAP_COLS);
  localparam logic [9:0] Y_SPAN = 10'(TILE_PX * MAP_ROWS);

  logic [10:0] dx, dy;
  logic        in_area;
  logic [9:0]  map_addr_q, map_addr_d;
  logic        s1_valid_q, s1_in_area_q;
  logic [3:0]  s1_px_q, s1_py_q;
  logic        s2_valid_q, s2_in_area_q;
  logic [11:0] tex_addr_q, tex_addr_d;
  color_t      rgb_q, rgb_d;
  tile_t       tile_id;
  logic [2:0]  sideband;

  always_comb begin
    // The borrow bit of the widened difference is the lower bound, so left/above pixels never alias
    dx         = {1'b0, pixel_x} - 11'(X_ORIGIN);
    dy         = {1'b0, pixel_y} - 11'(Y_ORIGIN);
    in_area    = !dx[10] && (dx[9:0] < X_SPAN) && !dy[10] && (dy[9:0] < Y_SPAN);
    map_en     = !rst && pixel_valid && in_area;
    map_addr_d = map_en ? {dy[TILE_BITS +: 5], dx[TILE_BITS +: 5]} : map_addr_q;
  end

  assign map_addr = map_addr_d;

`ifdef PLAYER_OVERLAY_EN
  logic       vsync_prev_q, vsync_prev_d;
  logic [4:0] player_col_q, player_col_d;
  logic [4:0] player_row_q, player_row_d;

  always_comb begin
    vsync_prev_d = vsync_i;
    player_col_d = player_col_q;
    player_row_d = player_row_q;
    if (vsync_prev_q && !vsync_i) begin
      player_col_d = player_col;
      player_row_d = player_row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev_q <= 1'b1;
      player_col_q <= '0;
      player_row_q <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      player_col_q <= player_col_d;
      player_row_q <= player_row_d;
    end
  end

  // map_addr_q holds the S1 pixel's tile address whenever S1 is in the maze area
  always_comb begin
    tile_id = map_dout;
    if (map_addr_q == {player_row_q, player_col_q}) begin
      tile_id = PLAYER_TILE;
    end
  end
`else
  logic unused_player;
  assign unused_player = ^{player_col, player_row};
  assign tile_id       = map_dout;
`endif

  always_comb begin
    tex_en     = s1_valid_q && s1_in_area_q;
    tex_addr_d = tex_en ? {tile_id, s1_py_q, s1_px_q} : tex_addr_q;
    if (!s2_valid_q) begin
      rgb_d = '0;
    end else if (!s2_in_area_q || tex_dout == KEY_COLOR) begin
      rgb_d = BG_COLOR;
    end else begin
      rgb_d = tex_dout;
    end
  end

  assign tex_addr = tex_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_in_area_q <= 1'b0;
      s1_px_q      <= '0;
      s1_py_q      <= '0;
      tex_addr_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_in_area_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      map_addr_q   <= map_addr_d;
      s1_valid_q   <= pixel_valid;
      s1_in_area_q <= in_area;
      s1_px_q      <= dx[3:0];
      s1_py_q      <= dy[3:0];
      tex_addr_q   <= tex_addr_d;
      s2_valid_q   <= s1_valid_q;
      s2_in_area_q <= s1_in_area_q;
      rgb_q        <= rgb_d;
    end
  end

  sync_delay #(
    .WIDTH    (3),
    .DEPTH    (3),
    .RESET_VAL(3'b110)
  ) u_sideband (
    .clk (clk),
    .rst (rst),
    .din ({hsync_i, vsync_i, pixel_valid}),
    .dout(sideband)
  );

  assign {hsync_o, vsync_o, rgb_valid} = sideband;
  assign rgb = rgb_q;

endmodule
